// File: rtl/rv_reduced_pkg.sv
// Shared encodings and types for the reduced RISC-V operand-fetch stage.
// Decoded set: ADDI, ADD and BNE; anything else is flagged illegal.
package rv_reduced_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [2:0] F3_ADD    = 3'b000;
   localparam logic [2:0] F3_BNE    = 3'b001;
   localparam logic [6:0] F7_ADD    = 7'b0000000;

   typedef enum logic [1:0] {
      IMM_I,
      IMM_B,
      IMM_NONE
   } imm_type_t;

   typedef struct packed {
      logic      alu_src;
      logic      reg_write;
      logic      branch;
      logic      illegal;
      imm_type_t imm_type;
   } ctrl_t;

   typedef struct packed {
      logic [XLEN-1:0]   reg_op1;
      logic [XLEN-1:0]   reg_op2;
      logic [XLEN-1:0]   imm_op;
      logic              alu_src;
      logic              reg_write;
      logic              branch;
      logic [REG_AW-1:0] rd;
      logic              illegal;
   } bundle_t;

   // Unsupported encodings fall through to NOP control with illegal set.
   function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
      ctrl_t c;
      c = '{alu_src: 1'b0, reg_write: 1'b0, branch: 1'b0, illegal: 1'b1,
            imm_type: IMM_NONE};
      if (instr[6:0] == OP_IMM && instr[14:12] == F3_ADD) begin
         c = '{alu_src: 1'b1, reg_write: 1'b1, branch: 1'b0, illegal: 1'b0,
               imm_type: IMM_I};
      end else if (instr[6:0] == OP_REG && instr[14:12] == F3_ADD &&
                   instr[31:25] == F7_ADD) begin
         c = '{alu_src: 1'b0, reg_write: 1'b1, branch: 1'b0, illegal: 1'b0,
               imm_type: IMM_NONE};
      end else if (instr[6:0] == OP_BRANCH && instr[14:12] == F3_BNE) begin
         c = '{alu_src: 1'b0, reg_write: 1'b0, branch: 1'b1, illegal: 1'b0,
               imm_type: IMM_B};
      end
      return c;
   endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Instruction-in / operand-bundle-out handshake plus the write-back port.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
interface operand_fetch_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           instr;
   logic                  flush;
   logic                  wb_en;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [DATA_WIDTH-1:0] wb_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] regOp1;
   logic [DATA_WIDTH-1:0] regOp2;
   logic [DATA_WIDTH-1:0] ImmOp;
   logic                  ALUsrc;
   logic                  RegWrite;
   logic                  Branch;
   logic [ADDR_WIDTH-1:0] rd;
   logic                  illegal;
   logic [DATA_WIDTH-1:0] a0;

   modport master (
      output in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
      input  in_ready, out_valid, regOp1, regOp2, ImmOp, ALUsrc, RegWrite,
             Branch, rd, illegal, a0
   );

   modport slave (
      input  in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
      output in_ready, out_valid, regOp1, regOp2, ImmOp, ALUsrc, RegWrite,
             Branch, rd, illegal, a0
   );
endinterface

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero, synchronous clear, and a debug tap on x10.
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] a0
);
   localparam int NREGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wen && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
   assign a0     = regs[ADDR_WIDTH'(10)];

endmodule

// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage: decodes one instruction per handshake, reads the
// register file with write-back bypass and holds the result in a one-slot output register.
module operand_fetch
   import rv_reduced_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN,
   parameter int ADDR_WIDTH = REG_AW
) (
   input logic           clk,
   input logic           rst,
   operand_fetch_if.slave bus
);
   logic [ADDR_WIDTH-1:0] rs1;
   logic [ADDR_WIDTH-1:0] rs2;
   logic [DATA_WIDTH-1:0] rf_rd1;
   logic [DATA_WIDTH-1:0] rf_rd2;
   logic                  wb_live;
   logic                  accept;
   ctrl_t                 ctrl;
   bundle_t               bundle_d;
   bundle_t               bundle_q;
   logic                  valid_q;

   assign rs1 = bus.instr[19:15];
   assign rs2 = bus.instr[24:20];

   reg_file #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_reg_file (
      .clk   (clk),
      .rst   (rst),
      .raddr1(rs1),
      .raddr2(rs2),
      .rdata1(rf_rd1),
      .rdata2(rf_rd2),
      .wen   (bus.wb_en),
      .waddr (bus.wb_addr),
      .wdata (bus.wb_data),
      .a0    (bus.a0)
   );

   assign ctrl    = decode_ctrl(bus.instr);
   assign wb_live = bus.wb_en && (bus.wb_addr != '0);

   always_comb begin
      bundle_d           = '0;
      // A same-cycle write-back wins over the stale register file contents.
      bundle_d.reg_op1   = (wb_live && bus.wb_addr == rs1) ? bus.wb_data : rf_rd1;
      bundle_d.reg_op2   = (wb_live && bus.wb_addr == rs2) ? bus.wb_data : rf_rd2;
      bundle_d.alu_src   = ctrl.alu_src;
      bundle_d.reg_write = ctrl.reg_write;
      bundle_d.branch    = ctrl.branch;
      bundle_d.illegal   = ctrl.illegal;
      bundle_d.rd        = bus.instr[11:7];
      case (ctrl.imm_type)
         IMM_I:   bundle_d.imm_op = {{20{bus.instr[31]}}, bus.instr[31:20]};
         IMM_B:   bundle_d.imm_op = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                                     bus.instr[30:25], bus.instr[11:8], 1'b0};
         default: bundle_d.imm_op = '0;
      endcase
   end

   assign bus.in_ready = !valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   // Flush beats accept; the bundle data is left as-is since out_valid gates it.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q  <= 1'b1;
         bundle_q <= bundle_d;
      end else if (valid_q && bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.regOp1    = bundle_q.reg_op1;
   assign bus.regOp2    = bundle_q.reg_op2;
   assign bus.ImmOp     = bundle_q.imm_op;
   assign bus.ALUsrc    = bundle_q.alu_src;
   assign bus.RegWrite  = bundle_q.reg_write;
   assign bus.Branch    = bundle_q.branch;
   assign bus.rd        = bundle_q.rd;
   assign bus.illegal   = bundle_q.illegal;

endmodule
